segment_decoder_rx: RTL and testbench

//  Receive-side counterpart of the two-digit hex-to-7-segment encoder: watches two 9-bit

---
 rtl/segment_decoder_rx.sv | 185 ++++++++++++++++++
 tb/tb_segment_decoder_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_decoder_rx.sv
// Two-channel 7-segment snoop decoder: recovers nibble/DP/DIG from stable segment patterns.
// Build option SEG_DEC_SYNC_EN inserts a 2-flop synchroniser on each seg_in bus.
module segment_decoder_rx #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [8:0]       seg_in_1,
  input  logic [8:0]       seg_in_2,
  output logic [3:0]       data_1,
  output logic [3:0]       data_2,
  output logic             dp_1,
  output logic             dp_2,
  output logic             dig_1,
  output logic             dig_2,
  output logic             blank_1,
  output logic             blank_2,
  output logic             valid_1,
  output logic             valid_2,
  output logic             err_1,
  output logic             err_2,
  output logic [CNT_W-1:0] err_cnt
);

  // state  | meaning
  // SETTLE | counting consecutive unchanged cycles of seg_q
  // REPORT | pattern held long enough; decode and pulse on the next edge
  // LOCKED | reported pattern still present; wait for any bit change
  typedef enum logic [1:0] {SETTLE, REPORT, LOCKED} state_t;

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  logic [1:0][3:0] data_v;
  logic [1:0]      dp_v, dig_v, blank_v, valid_v, err_v;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [8:0] seg_raw, seg_s, seg_q;
    logic [7:0] cnt, cnt_nxt;
    state_t     state, state_nxt;
    logic [3:0] data_r, nib;
    logic       dp_r, dig_r, blank_r, valid_r, err_r, legal;

    assign seg_raw = (g == 0) ? seg_in_1 : seg_in_2;

`ifdef SEG_DEC_SYNC_EN
    logic [8:0] sync_a, sync_b;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_a <= '0;
        sync_b <= '0;
      end else begin
        sync_a <= seg_raw;
        sync_b <= sync_a;
      end
    end
    assign seg_s = sync_b;
`else
    assign seg_s = seg_raw;
`endif

    always_comb begin
      legal = 1'b1;
      nib   = 4'h0;
      case (seg_q[6:0])
        7'h3F: nib = 4'h0;
        7'h06: nib = 4'h1;
        7'h5B: nib = 4'h2;
        7'h4F: nib = 4'h3;
        7'h66: nib = 4'h4;
        7'h6D: nib = 4'h5;
        7'h7D: nib = 4'h6;
        7'h07: nib = 4'h7;
        7'h7F: nib = 4'h8;
        7'h6F: nib = 4'h9;
        7'h77: nib = 4'hA;
        7'h7C: nib = 4'hB;
        7'h39: nib = 4'hC;
        7'h5E: nib = 4'hD;
        7'h79: nib = 4'hE;
        7'h71: nib = 4'hF;
        default: legal = 1'b0;
      endcase
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
        SETTLE: begin
          if (seg_s != seg_q) begin
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 8'd1;
            if (cnt_nxt == STABLE_LIM) state_nxt = REPORT;
          end
        end
        // A change landing on the report edge must still restart settling,
        // otherwise seg_q would already hold it and LOCKED would never see it.
        REPORT: begin
          cnt_nxt   = '0;
          state_nxt = (seg_s != seg_q) ? SETTLE : LOCKED;
        end
        LOCKED: begin
          if (seg_s != seg_q) begin
            cnt_nxt   = '0;
            state_nxt = SETTLE;
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state   <= SETTLE;
        seg_q   <= '0;
        cnt     <= '0;
        data_r  <= '0;
        dp_r    <= 1'b0;
        dig_r   <= 1'b0;
        blank_r <= 1'b0;
        valid_r <= 1'b0;
        err_r   <= 1'b0;
      end else begin
        state   <= state_nxt;
        seg_q   <= seg_s;
        cnt     <= cnt_nxt;
        valid_r <= 1'b0;
        err_r   <= 1'b0;
        if (state == REPORT) begin
          blank_r <= (seg_q[6:0] == 7'h00);
          if (seg_q[6:0] != 7'h00) begin
            if (legal) begin
              data_r  <= nib;
              dp_r    <= seg_q[7];
              dig_r   <= seg_q[8];
              valid_r <= 1'b1;
            end else begin
              err_r   <= 1'b1;
            end
          end
        end
      end
    end

    assign data_v[g]  = data_r;
    assign dp_v[g]    = dp_r;
    assign dig_v[g]   = dig_r;
    assign blank_v[g] = blank_r;
    assign valid_v[g] = valid_r;
    assign err_v[g]   = err_r;
  end

  // Counts the registered err pulses, so it trails them by one cycle.
  logic [CNT_W:0] cnt_sum;
  assign cnt_sum = {1'b0, err_cnt} + {{CNT_W{1'b0}}, err_v[0]} + {{CNT_W{1'b0}}, err_v[1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_sum[CNT_W]) begin
      err_cnt <= '1;
    end else begin
      err_cnt <= cnt_sum[CNT_W-1:0];
    end
  end

  assign data_1  = data_v[0];
  assign data_2  = data_v[1];
  assign dp_1    = dp_v[0];
  assign dp_2    = dp_v[1];
  assign dig_1   = dig_v[0];
  assign dig_2   = dig_v[1];
  assign blank_1 = blank_v[0];
  assign blank_2 = blank_v[1];
  assign valid_1 = valid_v[0];
  assign valid_2 = valid_v[1];
  assign err_1   = err_v[0];
  assign err_2   = err_v[1];

endmodule

// File: tb/tb_segment_decoder_rx.sv
// Self-checking bench for segment_decoder_rx: vector table, directed corner sequences,
// and random stimulus against a per-cycle behavioural reference model.
module tb_segment_decoder_rx;
  localparam int S     = 4;
  localparam int CNT_W = 8;
`ifdef SEG_DEC_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif
  localparam int LAT = S + 2 + SYNC_D;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [8:0] seg_in_1 = '0, seg_in_2 = '0;
  logic [3:0] data_1, data_2;
  logic dp_1, dp_2, dig_1, dig_2, blank_1, blank_2, valid_1, valid_2, err_1, err_2;
  logic [CNT_W-1:0] err_cnt;

  segment_decoder_rx #(.STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in_1(seg_in_1), .seg_in_2(seg_in_2),
    .data_1(data_1), .data_2(data_2), .dp_1(dp_1), .dp_2(dp_2),
    .dig_1(dig_1), .dig_2(dig_2), .blank_1(blank_1), .blank_2(blank_2),
    .valid_1(valid_1), .valid_2(valid_2), .err_1(err_1), .err_2(err_2),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int nv1, ne1, nv2, ne2, nboth;

  // Reference model: per channel, length of the current unchanged run and
  // whether that run is still owed a report.
  typedef struct {
    logic [8:0] q, p1, p2;
    int         run;
    bit         armed, pend;
    logic [3:0] data;
    logic       dp, dig, blank, valid, err;
  } ch_t;
  ch_t m[2];
  int  m_cnt;

  logic [6:0] code_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int lookup(input logic [6:0] v);
    for (int i = 0; i < 16; i++) if (code_tab[i] == v) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [8:0] x1, input logic [8:0] x2);
    int sum, idx;
    logic [8:0] x, xs;
    if (!r) begin
      for (int c = 0; c < 2; c++) begin
        m[c] = '{default: 0};
        m[c].armed = 1'b1;
      end
      m_cnt = 0;
      return;
    end
    sum = m_cnt + int'(m[0].err) + int'(m[1].err);
    m_cnt = (sum > 255) ? 255 : sum;
    for (int c = 0; c < 2; c++) begin
      x = (c == 0) ? x1 : x2;
      if (SYNC_D != 0) begin
        xs = m[c].p2;
        m[c].p2 = m[c].p1;
        m[c].p1 = x;
      end else begin
        xs = x;
      end
      m[c].valid = 1'b0;
      m[c].err   = 1'b0;
      if (m[c].pend) begin
        m[c].pend = 1'b0;
        idx = lookup(m[c].q[6:0]);
        m[c].blank = (m[c].q[6:0] == 7'h00);
        if (!m[c].blank) begin
          if (idx >= 0) begin
            m[c].data  = 4'(idx);
            m[c].dp    = m[c].q[7];
            m[c].dig   = m[c].q[8];
            m[c].valid = 1'b1;
          end else begin
            m[c].err = 1'b1;
          end
        end
      end
      if (xs != m[c].q) begin
        m[c].run   = 0;
        m[c].armed = 1'b1;
      end else begin
        m[c].run++;
        if (m[c].armed && m[c].run == S) begin
          m[c].pend  = 1'b1;
          m[c].armed = 1'b0;
        end
      end
      m[c].q = xs;
    end
  endtask

  function automatic logic [25:0] act_vec();
    return {data_1, dp_1, dig_1, blank_1, valid_1, err_1,
            data_2, dp_2, dig_2, blank_2, valid_2, err_2, err_cnt};
  endfunction

  function automatic logic [25:0] exp_vec();
    logic [7:0] c8;
    c8 = 8'(m_cnt);
    return {m[0].data, m[0].dp, m[0].dig, m[0].blank, m[0].valid, m[0].err,
            m[1].data, m[1].dp, m[1].dig, m[1].blank, m[1].valid, m[1].err, c8};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic r;
    logic [8:0] a, b;
    r = rst_n; a = seg_in_1; b = seg_in_2;
    @(posedge clk);
    #1;
    model_edge(r, a, b);
    chk("model", {6'b0, act_vec()}, {6'b0, exp_vec()});
    if (valid_1) nv1++;
    if (err_1) ne1++;
    if (valid_2) nv2++;
    if (err_2) ne2++;
    if (err_1 && err_2) nboth++;
  endtask

  task automatic clr();
    nv1 = 0; ne1 = 0; nv2 = 0; ne2 = 0; nboth = 0;
  endtask

  task automatic wait_pulse(input int ch, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!((ch == 1) ? (valid_1 | err_1) : (valid_2 | err_2)) && n < 40);
  endtask

  typedef struct {
    logic [8:0] seg;
    logic [3:0] data;
    logic       valid, err, blank;
  } vec_t;
  vec_t tbl[20];

  initial begin
    int n;
    logic [8:0] v;
    tbl[0]  = '{9'h03F, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{9'h106, 4'h1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{9'h05B, 4'h2, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{9'h1CF, 4'h3, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{9'h066, 4'h4, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{9'h0ED, 4'h5, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{9'h07D, 4'h6, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{9'h007, 4'h7, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{9'h000, 4'h7, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{9'h07F, 4'h8, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{9'h06F, 4'h9, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{9'h155, 4'h9, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{9'h077, 4'hA, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{9'h07C, 4'hB, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{9'h080, 4'hB, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{9'h039, 4'hC, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{9'h05E, 4'hD, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{9'h079, 4'hE, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{9'h071, 4'hF, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{9'h15E, 4'hD, 1'b1, 1'b0, 1'b0};
    clr();

    // Reset, then idle zero bus: blank level, no pulses
    step(); step();
    chk("rst_outputs", {6'b0, act_vec()}, 32'h0);
    rst_n = 1'b1;
    clr();
    repeat (10) step();
    chk("t1_blank_1", blank_1, 1);
    chk("t1_valid_cnt", nv1, 0);
    chk("t1_err_cnt_pulses", ne1, 0);
    chk("t1_err_cnt", err_cnt, 0);

    // Latency of one legal code
    seg_in_1 = 9'h04F;
    clr();
    wait_pulse(1, n);
    chk("t2_latency", n, LAT);
    chk("t2_valid", valid_1, 1);
    chk("t2_data", data_1, 4'h3);
    chk("t2_dp_dig", {dp_1, dig_1}, 2'b00);
    repeat (10) step();
    chk("t2_single_pulse", nv1, 1);

    // DP, then DIG: each bit change re-reports
    seg_in_2 = 9'h0F7;
    wait_pulse(2, n);
    chk("t3_valid", valid_2, 1);
    chk("t3_data", data_2, 4'hA);
    chk("t3_dp_dig", {dp_2, dig_2}, 2'b10);
    seg_in_2 = 9'h1F7;
    wait_pulse(2, n);
    chk("t3_valid_dig", valid_2, 1);
    chk("t3_dig", {data_2, dp_2, dig_2}, {4'hA, 2'b11});

    // Toggling faster than the stability window never reports
    clr();
    for (int i = 0; i < 10; i++) begin
      seg_in_1 = (i % 2 == 1) ? 9'h006 : 9'h03F;
      step(); step();
    end
    chk("t4_no_pulse", nv1 + ne1, 0);
    repeat (12) step();
    chk("t4_one_valid", nv1, 1);
    chk("t4_data", data_1, 4'h1);

    // Illegal code on both channels in one cycle, then saturation
    clr();
    seg_in_1 = 9'h055; seg_in_2 = 9'h055;
    repeat (S + 6 + SYNC_D) step();
    chk("t5_err_both", nboth, 1);
    chk("t5_valid_none", nv1 + nv2, 0);
    chk("t5_err_cnt", err_cnt, 2);
    chk("t5_data_held", {data_1, data_2}, {4'h1, 4'hA});
    for (int i = 0; i < 140; i++) begin
      v = (i % 2 == 0) ? 9'h056 : 9'h055;
      seg_in_1 = v; seg_in_2 = v;
      repeat (S + 3) step();
    end
    repeat (12) step();
    chk("t5_saturated", err_cnt, 255);

    // Vector table on channel 1
    for (int i = 0; i < 20; i++) begin
      clr();
      seg_in_1 = tbl[i].seg;
      repeat (S + 4 + SYNC_D) step();
      chk($sformatf("tbl%0d_valid", i), nv1, tbl[i].valid);
      chk($sformatf("tbl%0d_err", i), ne1, tbl[i].err);
      chk($sformatf("tbl%0d_data", i), data_1, tbl[i].data);
      chk($sformatf("tbl%0d_blank", i), blank_1, tbl[i].blank);
    end

    // Reset during SETTLE and during LOCKED
    seg_in_1 = 9'h03F;
    step(); step();
    rst_n = 1'b0;
    seg_in_1 = 9'h07D;
    step();
    chk("t6_rst_settle", {6'b0, act_vec()}, 32'h0);
    rst_n = 1'b1;
    wait_pulse(1, n);
    chk("t6_relatency_a", n, LAT);
    chk("t6_data_a", data_1, 4'h6);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    chk("t6_rst_locked", {6'b0, act_vec()}, 32'h0);
    rst_n = 1'b1;
    wait_pulse(1, n);
    chk("t6_relatency_b", n, LAT);
    chk("t6_data_b", data_1, 4'h6);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 4) == 0) begin
          if ($urandom_range(0, 1) == 0)
            v = {2'($urandom_range(0, 3)), code_tab[$urandom_range(0, 15)]};
          else
            v = 9'($urandom);
          if (c == 0) seg_in_1 = v; else seg_in_2 = v;
        end
      end
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
